imem_loader: RTL and testbench

- Boot-time program loader for the instruction memory.
- Takes a byte stream from the UART receiver, checks the frame, and assembles little-endian 32-bit words.
- Drives the instruction memory write port and holds the CPU in reset until a complete, checksum-valid image is written.
- Sits between uart_rx and the imem write port; its cpu_reset output feeds the processor reset.

---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses a framed UART byte stream
// (0xA5, N, 4*N little-endian data bytes, XOR checksum), writes the words into
// instruction memory and releases the CPU reset only after a valid image.
module imem_loader #(
    parameter int DEPTH_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               reload,
    output logic               we,
    output logic [DEPTH_W-1:0] wa,
    output logic [31:0]        wd,
    output logic               cpu_reset,
    output logic               busy,
    output logic               err,
    output logic [DEPTH_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        SYNC,
        COUNT,
        DATA,
        CSUM,
        RUN,
        ERROR
    } state_t;

    localparam int             MAX_WORDS = 1 << DEPTH_W;
    localparam logic [7:0]     SYNC_BYTE = 8'hA5;
    localparam logic [DEPTH_W-1:0] WA_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_W:0]   WL_ONE = {{DEPTH_W{1'b0}}, 1'b1};

    state_t               state, state_next;
    logic [DEPTH_W:0]     count, count_next;
    logic [DEPTH_W-1:0]   word_idx, word_idx_next;
    logic [1:0]           byte_idx, byte_idx_next;
    logic [23:0]          asm_word, asm_word_next;
    logic [7:0]           csum, csum_next;
    logic                 we_next;
    logic [DEPTH_W-1:0]   wa_next;
    logic [31:0]          wd_next;
    logic                 cpu_reset_next;
    logic                 busy_next;
    logic                 err_next;
    logic [DEPTH_W:0]     words_loaded_next;

    // Register the FSM state, the frame datapath and every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SYNC;
            count        <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            asm_word     <= '0;
            csum         <= '0;
            we           <= 1'b0;
            wa           <= '0;
            wd           <= '0;
            cpu_reset    <= 1'b1;
            busy         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            word_idx     <= word_idx_next;
            byte_idx     <= byte_idx_next;
            asm_word     <= asm_word_next;
            csum         <= csum_next;
            we           <= we_next;
            wa           <= wa_next;
            wd           <= wd_next;
            cpu_reset    <= cpu_reset_next;
            busy         <= busy_next;
            err          <= err_next;
            words_loaded <= words_loaded_next;
        end
    end

    // Frame parser: next state, word assembly, checksum and write strobe.
    // Status outputs are derived from the next state so that they line up
    // exactly with the registered state.
    always_comb begin
        state_next        = state;
        count_next        = count;
        word_idx_next     = word_idx;
        byte_idx_next     = byte_idx;
        asm_word_next     = asm_word;
        csum_next         = csum;
        we_next           = 1'b0;
        wa_next           = wa;
        wd_next           = wd;
        words_loaded_next = words_loaded;

        case (state)
            SYNC: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_next        = COUNT;
                    csum_next         = '0;
                    words_loaded_next = '0;
                end
            end

            COUNT: begin
                if (rx_valid) begin
                    count_next    = rx_data[DEPTH_W:0];
                    word_idx_next = '0;
                    byte_idx_next = '0;
                    csum_next     = '0;
                    if (rx_data == 8'h00) begin
                        state_next = CSUM;
                    end else if (int'(rx_data) > MAX_WORDS) begin
                        state_next = ERROR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (rx_valid) begin
                    csum_next     = csum ^ rx_data;
                    byte_idx_next = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: asm_word_next[7:0]   = rx_data;
                        2'd1: asm_word_next[15:8]  = rx_data;
                        2'd2: asm_word_next[23:16] = rx_data;
                        default: begin
                            we_next           = 1'b1;
                            wa_next           = word_idx;
                            wd_next           = {rx_data, asm_word};
                            words_loaded_next = words_loaded + WL_ONE;
                            word_idx_next     = word_idx + WA_ONE;
                            if (words_loaded_next == count) begin
                                state_next = CSUM;
                            end
                        end
                    endcase
                end
            end

            CSUM: begin
                if (rx_valid) begin
                    state_next = (rx_data == csum) ? RUN : ERROR;
                end
            end

            RUN, ERROR: begin
                if (reload) begin
                    state_next        = SYNC;
                    words_loaded_next = '0;
                    csum_next         = '0;
                    word_idx_next     = '0;
                    byte_idx_next     = '0;
                end
            end

            default: begin
                state_next = SYNC;
            end
        endcase

        cpu_reset_next = (state_next != RUN);
        busy_next      = (state_next == COUNT) || (state_next == DATA) || (state_next == CSUM);
        err_next       = (state_next == ERROR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against a byte-position model of the loader
// protocol; a negedge process compares every output each cycle.
module tb_imem_loader;

    localparam int DEPTH_W = 6;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         rx_data = 8'h00;
    logic               rx_valid = 1'b0;
    logic               reload = 1'b0;
    logic               we;
    logic [DEPTH_W-1:0] wa;
    logic [31:0]        wd;
    logic               cpu_reset;
    logic               busy;
    logic               err;
    logic [DEPTH_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH_W(DEPTH_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .reload       (reload),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    // Protocol model: position of the byte inside the current frame.
    bit          m_in_frame;
    bit          m_run;
    bit          m_err;
    int          m_pos;
    int          m_n;
    int          m_words;
    logic [7:0]  m_xor;
    logic [31:0] m_word;
    logic        exp_we;
    logic [5:0]  exp_wa;
    logic [31:0] exp_wd;

    logic [5:0]  log_wa[$];
    logic [31:0] log_wd[$];
    logic [7:0]  frame_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("we", {31'd0, we}, {31'd0, exp_we});
            checkOutput("wa", {26'd0, wa}, {26'd0, exp_wa});
            checkOutput("wd", wd, exp_wd);
            checkOutput("cpu_reset", {31'd0, cpu_reset}, {31'd0, !m_run});
            checkOutput("busy", {31'd0, busy}, {31'd0, m_in_frame});
            checkOutput("err", {31'd0, err}, {31'd0, m_err});
            checkOutput("words_loaded", {25'd0, words_loaded}, m_words);
            if (we === 1'b1) begin
                log_wa.push_back(wa);
                log_wd.push_back(wd);
            end
        end
    end

    task automatic modelByte(input logic [7:0] b);
        int idx;
        if (m_run || m_err) return;
        if (!m_in_frame) begin
            if (b == 8'hA5) begin
                m_in_frame = 1'b1;
                m_pos      = 0;
            end
        end else if (m_pos == 0) begin
            m_n     = int'(b);
            m_xor   = 8'h00;
            m_words = 0;
            if (m_n > 64) begin
                m_in_frame = 1'b0;
                m_err      = 1'b1;
            end else begin
                m_pos = 1;
            end
        end else if (m_pos <= 4 * m_n) begin
            idx   = m_pos - 1;
            m_xor = m_xor ^ b;
            m_word[(idx % 4) * 8 +: 8] = b;
            if (idx % 4 == 3) begin
                exp_we = 1'b1;
                exp_wa = 6'(idx / 4);
                exp_wd = m_word;
                m_words++;
            end
            m_pos++;
        end else begin
            m_in_frame = 1'b0;
            if (b == m_xor) m_run = 1'b1;
            else            m_err = 1'b1;
        end
    endtask

    // One clock of stimulus; the model is advanced right after the edge.
    task automatic applyStimulus(input bit v, input logic [7:0] b, input bit rel);
        bit took;
        rx_valid = v;
        rx_data  = b;
        reload   = rel;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        exp_we   = 1'b0;
        took     = 1'b0;
        if (rel && (m_run || m_err)) begin
            m_run      = 1'b0;
            m_err      = 1'b0;
            m_in_frame = 1'b0;
            m_words    = 0;
            took       = 1'b1;
        end
        if (v && !took) modelByte(b);
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulseReload();
        applyStimulus(1'b0, 8'h00, 1'b1);
    endtask

    task automatic sendFrame();
        foreach (frame_q[i]) sendByte(frame_q[i]);
    endtask

    task automatic doReset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        reload   = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b0;
        m_in_frame = 1'b0;
        m_run      = 1'b0;
        m_err      = 1'b0;
        m_pos      = 0;
        m_n        = 0;
        m_words    = 0;
        m_xor      = 8'h00;
        m_word     = 32'h0;
        exp_we     = 1'b0;
        exp_wa     = 6'd0;
        exp_wd     = 32'h0;
        check_en   = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] x;

        // Reset then idle.
        doReset();
        idle(20);
        checkOutput("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);

        // Two-word frame preceded by a junk byte; data XOR is 0x10.
        log_wa.delete();
        log_wd.delete();
        frame_q = '{8'h11, 8'hA5, 8'h02, 8'h0F, 8'h00, 8'h4F, 8'hE0,
                    8'h0F, 8'h10, 8'h4F, 8'hE0, 8'h10};
        sendFrame();
        checkOutput("f1_writes", log_wa.size(), 32'd2);
        if (log_wa.size() == 2) begin
            checkOutput("f1_wa0", {26'd0, log_wa[0]}, 32'd0);
            checkOutput("f1_wd0", log_wd[0], 32'hE04F000F);
            checkOutput("f1_wa1", {26'd0, log_wa[1]}, 32'd1);
            checkOutput("f1_wd1", log_wd[1], 32'hE04F100F);
        end
        checkOutput("f1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        checkOutput("f1_words", {25'd0, words_loaded}, 32'd2);
        sendByte(8'hA5);
        sendByte(8'h01);
        idle(3);

        // Same frame with a bad checksum, then reload with a colliding byte.
        pulseReload();
        checkOutput("reload_words", {25'd0, words_loaded}, 32'd0);
        log_wa.delete();
        log_wd.delete();
        frame_q = '{8'hA5, 8'h02, 8'h0F, 8'h00, 8'h4F, 8'hE0,
                    8'h0F, 8'h10, 8'h4F, 8'hE0, 8'h01};
        sendFrame();
        checkOutput("f2_err", {31'd0, err}, 32'd1);
        checkOutput("f2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        idle(2);
        checkOutput("f2_writes", log_wa.size(), 32'd2);
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("f2_reload_err", {31'd0, err}, 32'd0);
        idle(2);

        // Oversized count.
        log_wa.delete();
        sendByte(8'hA5);
        sendByte(8'h41);
        checkOutput("f3_err", {31'd0, err}, 32'd1);
        checkOutput("f3_busy", {31'd0, busy}, 32'd0);
        idle(2);
        checkOutput("f3_writes", log_wa.size(), 32'd0);
        pulseReload();

        // Empty image.
        sendByte(8'hA5);
        sendByte(8'h00);
        sendByte(8'h00);
        checkOutput("f4_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        checkOutput("f4_words", {25'd0, words_loaded}, 32'd0);
        pulseReload();

        // Full 64-word image.
        log_wa.delete();
        log_wd.delete();
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'h40);
        x = 8'h00;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i * 37 + 5);
            frame_q.push_back(b);
            x = x ^ b;
        end
        frame_q.push_back(x);
        sendFrame();
        checkOutput("f5_writes", log_wa.size(), 32'd64);
        if (log_wa.size() == 64) begin
            checkOutput("f5_wd0", log_wd[0], 32'h744F2A05);
            checkOutput("f5_last_wa", {26'd0, log_wa[63]}, 32'd63);
        end
        checkOutput("f5_words", {25'd0, words_loaded}, 32'd64);
        checkOutput("f5_cpu_reset", {31'd0, cpu_reset}, 32'd0);

        // Reset mid-word, then a fresh frame with reload ignored in COUNT.
        pulseReload();
        log_wa.delete();
        log_wd.delete();
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        doReset();
        checkOutput("f6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("f6_busy", {31'd0, busy}, 32'd0);
        idle(2);
        sendByte(8'hA5);
        pulseReload();
        checkOutput("f6_count_busy", {31'd0, busy}, 32'd1);
        frame_q = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        sendFrame();
        checkOutput("f6_writes", log_wa.size(), 32'd1);
        if (log_wa.size() == 1) begin
            checkOutput("f6_wa0", {26'd0, log_wa[0]}, 32'd0);
            checkOutput("f6_wd0", log_wd[0], 32'h12345678);
        end
        checkOutput("f6_run", {31'd0, cpu_reset}, 32'd0);
        idle(3);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
